// File: rtl/pc_ras_unit.sv
// Program counter with a source mux and a circular return-address stack.
// All state advances on the falling edge of Clk; PC_Next previews the mux.
module pc_ras_unit #(
  parameter int                WIDTH        = 16,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = 16'h3000
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Load_PC,
  input  logic [1:0]                  PCMUX_Control,
  input  logic [WIDTH-1:0]            PCMUX_Bus,
  input  logic [WIDTH-1:0]            PCMUX_Adder,
  input  logic                        Push,
  input  logic                        Clear_Flags,
  output logic [WIDTH-1:0]            PC,
  output logic [WIDTH-1:0]            PC_Next,
  output logic [$clog2(RAS_DEPTH):0]  RAS_Count,
  output logic                        RAS_Empty,
  output logic                        RAS_Full,
  output logic                        RAS_Overflow,
  output logic                        RAS_Underflow
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SEL_INC   = 2'b00;
  localparam logic [1:0] SEL_ADDER = 2'b01;
  localparam logic [1:0] SEL_BUS   = 2'b10;

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic [WIDTH-1:0] pc_reg;
  logic [PW-1:0]    top_reg;
  logic [CW-1:0]    count_reg;
  logic             ovf_reg;
  logic             unf_reg;

  logic [PW-1:0]    top_next;
  logic [CW-1:0]    count_next;
  logic             ovf_next;
  logic             unf_next;

  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_mux;
  logic [WIDTH-1:0] top_entry;
  logic [PW-1:0]    top_inc;
  logic             ras_empty;
  logic             ras_full;
  logic             is_pop;

  logic             wr_en;
  logic [PW-1:0]    wr_ptr;
  logic [WIDTH-1:0] wr_data;

  assign pc_inc    = pc_reg + WIDTH'(1);
  assign top_inc   = top_reg + PW'(1);
  assign top_entry = ras_mem[top_reg];
  assign ras_empty = (count_reg == '0);
  assign ras_full  = (count_reg == CW'(RAS_DEPTH));
  assign is_pop    = (PCMUX_Control == 2'b11);

  // A return with nothing stacked falls back to the bus value.
  always_comb begin
    pc_mux = pc_inc;
    case (PCMUX_Control)
      SEL_INC:   pc_mux = pc_inc;
      SEL_ADDER: pc_mux = PCMUX_Adder;
      SEL_BUS:   pc_mux = PCMUX_Bus;
      default:   pc_mux = ras_empty ? PCMUX_Bus : top_entry;
    endcase
  end

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg & ~Clear_Flags;
    unf_next   = unf_reg & ~Clear_Flags;
    wr_en      = 1'b0;
    wr_ptr     = top_inc;
    wr_data    = pc_inc;

    if (Load_PC) begin
      if (is_pop) begin
        if (ras_empty) begin
          unf_next = 1'b1;
          if (Push) begin
            wr_en      = 1'b1;
            top_next   = top_inc;
            count_next = CW'(1);
          end
        end else if (Push) begin
          // Tail call through a return: the popped slot is reused in place.
          wr_en  = 1'b1;
          wr_ptr = top_reg;
        end else begin
          top_next   = top_reg - PW'(1);
          count_next = count_reg - CW'(1);
        end
      end else if (Push) begin
        wr_en    = 1'b1;
        top_next = top_inc;
        if (ras_full) begin
          ovf_next = 1'b1;
        end else begin
          count_next = count_reg + CW'(1);
        end
      end
    end
  end

  always_ff @(negedge Clk) begin
    if (Reset) begin
      pc_reg    <= RESET_VECTOR;
      top_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      if (Load_PC) begin
        pc_reg <= pc_mux;
      end
      top_reg   <= top_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      unf_reg   <= unf_next;
    end
  end

  // Entry storage is never cleared; count alone decides what is valid.
  always_ff @(negedge Clk) begin
    if (wr_en && !Reset) begin
      ras_mem[wr_ptr] <= wr_data;
    end
  end

  assign PC            = pc_reg;
  assign PC_Next       = pc_mux;
  assign RAS_Count     = count_reg;
  assign RAS_Empty     = ras_empty;
  assign RAS_Full      = ras_full;
  assign RAS_Overflow  = ovf_reg;
  assign RAS_Underflow = unf_reg;

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the PC and data path width in bits.
REQ-002 The block SHALL have parameter RAS_DEPTH, default 4, giving the number of return-address-stack entries (power of two, >=2).
REQ-003 The block SHALL have parameter RESET_VECTOR, default 16'h3000 (WIDTH bits), giving the PC value loaded on reset.
REQ-004 Clk  input  1  clock; all state SHALL update on the falling edge of Clk.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on the falling edge of Clk.
REQ-006 Load_PC  input  1  enables a PC update this cycle.
REQ-007 PCMUX_Control  input  2  source select: 00 PC+1, 01 PCMUX_Adder, 10 PCMUX_Bus, 11 pop from RAS.
REQ-008 PCMUX_Bus  input  WIDTH  bus value, also used as the fallback target on RAS underflow.
REQ-009 PCMUX_Adder  input  WIDTH  address-adder value.
REQ-010 Push  input  1  subroutine call: push PC+1 onto the RAS when qualified by Load_PC.
REQ-011 Clear_Flags  input  1  clears the sticky error flags.
REQ-012 PC  output  WIDTH  registered program counter.
REQ-013 PC_Next  output  WIDTH  combinational value PC will take at the next edge if Load_PC=1.
REQ-014 RAS_Count  output  clog2(RAS_DEPTH)+1  number of valid RAS entries.
REQ-015 RAS_Empty / RAS_Full  output  1 each  RAS_Count==0 / RAS_Count==RAS_DEPTH.
REQ-016 RAS_Overflow / RAS_Underflow  output  1 each  sticky error flags.

Function
REQ-017 PC+1 SHALL be computed modulo 2^WIDTH; all-ones increments to zero.
REQ-018 PC_Next SHALL be PC+1, PCMUX_Adder, PCMUX_Bus for selects 00/01/10, respectively.
REQ-019 For select 11, PC_Next SHALL be the RAS top entry when RAS_Empty=0, else PCMUX_Bus.
REQ-020 With Load_PC=0, PC, RAS contents, RAS_Count and flags SHALL hold; Push and select 11 SHALL be ignored.
REQ-021 With Load_PC=1, PC SHALL take PC_Next at the edge (one-cycle latency).
REQ-022 The RAS SHALL be a circular buffer: top pointer plus count; the pushed value SHALL be the PC+1 of the current cycle (pre-update PC).
REQ-023 Push with Load_PC=1, select!=11, not full: write at top+1, top advances, count+1.
REQ-024 Push when full: write at top+1 overwriting the oldest entry, count stays RAS_DEPTH, RAS_Overflow SHALL set.
REQ-025 Select 11 with Load_PC=1, Push=0, not empty: top retreats, count-1.
REQ-026 Select 11 with Load_PC=1 when empty: PC takes PCMUX_Bus, count stays 0, RAS_Underflow SHALL set.
REQ-027 Select 11 and Push together (tail call via return) when not empty: PC takes old top; top entry is replaced by PC+1; count unchanged.
REQ-028 Select 11 and Push together when empty: PC takes PCMUX_Bus, one entry (PC+1) is pushed, count=1, RAS_Underflow SHALL set.
REQ-029 Flags SHALL be sticky until Clear_Flags=1 or Reset; a set condition in the same cycle as Clear_Flags SHALL take precedence (flag ends set).
REQ-030 RAS entry contents SHALL be unobservable except via pop; entries beyond count are don't-care.

Reset
REQ-031 Reset SHALL take priority over all other inputs, including Load_PC and Push.
REQ-032 On Reset: PC=RESET_VECTOR, RAS_Count=0, top pointer=0, RAS_Empty=1, RAS_Full=0, both flags=0; entry storage need not clear.
REQ-033 Reset asserted mid-sequence (RAS partially filled) SHALL discard all entries; a subsequent pop SHALL underflow.

Verification
REQ-034 Reset, then Load_PC=1, select 00 for 3 cycles -> PC 3000, 3001, 3002, 3003; Load_PC=0 one cycle -> PC holds 3003.
REQ-035 PC=FFFF, select 00 -> PC=0000; select 01 with Adder=1234 -> 1234; select 10 with Bus=ABCD -> ABCD.
REQ-036 From PC=3000, Push+select 01 (Adder=4000); PC=4000, Push+select 01 (Adder=5000); then select 11 twice -> PC 5000, 4001, 3001; count 1,2,1,0; flags 0.
REQ-037 Five pushes from PCs 1000..1004 (depth 4) -> RAS_Full=1, RAS_Overflow=1; four pops -> 1005,1004,1003,1002; fifth pop with Bus=0777 -> PC=0777, RAS_Underflow=1; Clear_Flags -> both 0.
REQ-038 Count=2, top=4001; select 11+Push at PC=6000 -> PC=4001, count 2, next pop -> 6001.
REQ-039 Count=3, Reset asserted with Load_PC=1, Push=1 -> PC=3000, count 0, RAS_Empty=1; pop with Bus=0042 -> PC=0042, RAS_Underflow=1.
